// File: rtl/timekeep_pkg.sv
// timekeep_pkg -- shared definitions for the time-of-day keeper.
//   tk_mode_e : edit-mode state encoding, also driven out on the mode port
//               (0 RUN, 1 SET_HOUR, 2 SET_MIN).
//   *_MAX     : wrap limits of the seconds, minutes and hours fields.
//   *_W       : bit widths of those fields on the output bus.
package timekeep_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } tk_mode_e;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

endpackage

// File: rtl/timekeep_ctrl_if.sv
// timekeep_ctrl_if -- bus between the time keeper and its environment.
//   ms_tick  : 1 ms timebase pulse (one cycle)
//   btn_mode : debounced mode button pulse
//   btn_inc  : debounced increment button pulse
//   sec/min/hour : current time of day
//   mode     : current edit state (0 RUN, 1 SET_HOUR, 2 SET_MIN)
//   blink    : blink enable for the field being edited
// master modport drives the pulses and observes the time; slave is the keeper.
interface timekeep_ctrl_if;

    logic       ms_tick;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output ms_tick, btn_mode, btn_inc,
        input  sec, min, hour, mode, blink
    );

    modport slave (
        input  ms_tick, btn_mode, btn_inc,
        output sec, min, hour, mode, blink
    );

endinterface

// File: rtl/mod_counter.sv
// mod_counter -- registered modulo counter 0..MAX used for each time field.
//   clk, reset : clock, asynchronous active-low reset
//   en         : advance by one this cycle (wraps MAX -> 0)
//   clear      : synchronous clear to 0, overrides en
//   count      : registered count value
//   carry      : combinational pulse in the cycle the counter wraps, so a
//                chain of counters ripples in a single clock
module mod_counter #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned MAX   = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;

    assign at_max = (count_q == WIDTH'(MAX));
    assign carry  = en && at_max && !clear;
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = at_max ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/timekeep_ctrl.sv
// timekeep_ctrl -- 24 h time-of-day keeper with a two-field edit mode.
//   clk   : sole clock
//   reset : asynchronous active-low reset
//   tk    : slave side of timekeep_ctrl_if (ms_tick/btn_mode/btn_inc in,
//           sec/min/hour/mode/blink out, all outputs registered)
// Parameters: MS_PER_SEC ms ticks per second, BLINK_MS ticks per blink
// half-period.
module timekeep_ctrl
    import timekeep_pkg::*;
#(
    parameter int unsigned MS_PER_SEC = 1000,
    parameter int unsigned BLINK_MS   = 500
) (
    input  logic          clk,
    input  logic          reset,
    timekeep_ctrl_if.slave tk
);

    localparam int unsigned MS_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam int unsigned BL_W = (BLINK_MS > 1)   ? $clog2(BLINK_MS)   : 1;

    tk_mode_e            state_q, state_d;
    logic [MS_W-1:0]     ms_cnt_q, ms_cnt_d;
    logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                blink_q, blink_d;

    logic                in_run;
    logic                enter_set;
    logic                leave_set;
    logic                edit_inc;
    logic                sec_tick;

    logic [SEC_W-1:0]    sec_q;
    logic [MIN_W-1:0]    min_q;
    logic [HOUR_W-1:0]   hour_q;
    logic                sec_carry, min_carry, hour_carry_unused;
    logic                min_en, hour_en;

    // All decisions use the pre-transition state, so an ms_tick coinciding
    // with btn_mode is handled as if the button had not yet been pressed.
    assign in_run    = (state_q == RUN);
    assign enter_set = in_run && tk.btn_mode;
    assign leave_set = (state_q == SET_MIN) && tk.btn_mode;
    assign edit_inc  = tk.btn_inc && !tk.btn_mode;   // mode press wins
    assign sec_tick  = in_run && tk.ms_tick &&
                       (ms_cnt_q == MS_W'(MS_PER_SEC - 1));

    // In RUN the fields ripple via carries; in edit states only the edited
    // field moves and its carry is ignored.
    assign min_en  = in_run ? sec_carry : ((state_q == SET_MIN)  && edit_inc);
    assign hour_en = in_run ? min_carry : ((state_q == SET_HOUR) && edit_inc);

    always_comb begin
        state_d = state_q;
        if (tk.btn_mode) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                SET_MIN:  state_d = RUN;
                default:  state_d = RUN;
            endcase
        end

        ms_cnt_d = ms_cnt_q;
        if (leave_set) begin
            ms_cnt_d = '0;
        end else if (in_run && tk.ms_tick) begin
            ms_cnt_d = sec_tick ? '0 : ms_cnt_q + MS_W'(1);
        end

        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (enter_set) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (in_run || leave_set) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (tk.ms_tick) begin
            if (blink_cnt_q == BL_W'(BLINK_MS - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            ms_cnt_q    <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ms_cnt_q    <= ms_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .reset (reset),
        .en    (sec_tick),
        .clear (leave_set),
        .count (sec_q),
        .carry (sec_carry)
    );

    mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .reset (reset),
        .en    (min_en),
        .clear (1'b0),
        .count (min_q),
        .carry (min_carry)
    );

    mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk   (clk),
        .reset (reset),
        .en    (hour_en),
        .clear (1'b0),
        .count (hour_q),
        .carry (hour_carry_unused)
    );

    assign tk.sec   = sec_q;
    assign tk.min   = min_q;
    assign tk.hour  = hour_q;
    assign tk.mode  = state_q;
    assign tk.blink = blink_q;

endmodule

// File: tb/tb_timekeep_ctrl.sv
// tb_timekeep_ctrl -- directed self-checking bench for timekeep_ctrl.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_timekeep_ctrl;

    logic clk;
    logic reset;

    int unsigned n_compared;
    int unsigned n_mismatched;

    timekeep_ctrl_if tk_if ();

    timekeep_ctrl #(
        .MS_PER_SEC (1000),
        .BLINK_MS   (500)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tk    (tk_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given input pulses; returns at the next falling edge.
    task automatic step(input logic ms, input logic md, input logic inc);
        tk_if.ms_tick  = ms;
        tk_if.btn_mode = md;
        tk_if.btn_inc  = inc;
        @(negedge clk);
        tk_if.ms_tick  = 1'b0;
        tk_if.btn_mode = 1'b0;
        tk_if.btn_inc  = 1'b0;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic incs(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_time(input string tag, input int unsigned h,
                              input int unsigned m, input int unsigned s);
        check_eq({tag, "_hour"}, 32'(tk_if.hour), h);
        check_eq({tag, "_min"},  32'(tk_if.min),  m);
        check_eq({tag, "_sec"},  32'(tk_if.sec),  s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        prev_blink;
        int unsigned toggles;

        n_compared     = 0;
        n_mismatched   = 0;
        reset          = 1'b0;
        tk_if.ms_tick  = 1'b0;
        tk_if.btn_mode = 1'b0;
        tk_if.btn_inc  = 1'b0;
        repeat (3) @(negedge clk);

        check_time("reset", 0, 0, 0);
        check_eq("reset_mode",  32'(tk_if.mode),  0);
        check_eq("reset_blink", 32'(tk_if.blink), 0);
        reset = 1'b1;
        @(negedge clk);

        // First second: sec flips exactly on the 1000th tick.
        ticks(999);
        check_time("t999", 0, 0, 0);
        ticks(1);
        check_time("t1000", 0, 0, 1);

        // btn_inc ignored in RUN.
        incs(3);
        check_time("run_inc", 0, 0, 1);
        check_eq("run_mode", 32'(tk_if.mode), 0);

        // Leave prescaler mid-count so its clear on exit is observable.
        ticks(300);
        check_time("pre_edit", 0, 0, 1);

        step(1'b0, 1'b1, 1'b0);
        check_eq("edit_mode_h",  32'(tk_if.mode),  1);
        check_eq("edit_blink_h", 32'(tk_if.blink), 1);
        incs(25);
        check_eq("hour_wrap_inc", 32'(tk_if.hour), 1);
        step(1'b0, 1'b1, 1'b0);
        check_eq("edit_mode_m", 32'(tk_if.mode), 2);
        incs(61);
        check_time("min_wrap_inc", 1, 1, 1);
        step(1'b0, 1'b1, 1'b0);
        check_eq("exit_mode",  32'(tk_if.mode),  0);
        check_eq("exit_blink", 32'(tk_if.blink), 0);
        check_time("exit_sec_clr", 1, 1, 0);
        ticks(999);
        check_time("presc_clr_999", 1, 1, 0);
        ticks(1);
        check_time("presc_clr_1000", 1, 1, 1);

        // Preload 23:59 then count up to 23:59:59.
        step(1'b0, 1'b1, 1'b0);
        incs(22);
        step(1'b0, 1'b1, 1'b0);
        incs(58);
        step(1'b0, 1'b1, 1'b0);
        check_time("preload", 23, 59, 0);
        ticks(59000);
        check_time("pre_midnight", 23, 59, 59);
        ticks(999);
        check_time("midnight_999", 23, 59, 59);
        ticks(1);
        check_time("midnight", 0, 0, 0);

        // Simultaneous mode and inc: mode wins, inc dropped.
        step(1'b0, 1'b1, 1'b1);
        check_eq("both_mode", 32'(tk_if.mode), 1);
        check_eq("both_hour", 32'(tk_if.hour), 0);

        // Frozen time and blink cadence in SET_HOUR.
        incs(5);
        check_eq("set_hour5", 32'(tk_if.hour), 5);
        ticks(499);
        check_eq("blink_499", 32'(tk_if.blink), 1);
        ticks(1);
        check_eq("blink_500", 32'(tk_if.blink), 0);
        prev_blink = tk_if.blink;
        toggles    = 1;
        for (int unsigned i = 0; i < 1500; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (tk_if.blink !== prev_blink) toggles++;
            prev_blink = tk_if.blink;
        end
        check_eq("blink_toggles", toggles, 4);
        check_eq("blink_2000", 32'(tk_if.blink), 1);
        check_time("frozen", 5, 0, 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_eq("back_run_mode",  32'(tk_if.mode),  0);
        check_eq("back_run_blink", 32'(tk_if.blink), 0);

        // Tick coinciding with mode press is counted under RUN.
        ticks(999);
        check_time("pre_coinc", 5, 0, 0);
        step(1'b1, 1'b1, 1'b0);
        check_time("coinc", 5, 0, 1);
        check_eq("coinc_mode", 32'(tk_if.mode), 1);

        // Set 12:34 then reset asynchronously mid-edit.
        incs(7);
        step(1'b0, 1'b1, 1'b0);
        incs(34);
        check_time("pre_rst", 12, 34, 1);
        check_eq("pre_rst_mode", 32'(tk_if.mode), 2);
        #2;
        reset = 1'b0;
        #1;
        check_time("async_rst", 0, 0, 0);
        check_eq("async_rst_mode",  32'(tk_if.mode),  0);
        check_eq("async_rst_blink", 32'(tk_if.blink), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ticks(999);
        check_time("resume_999", 0, 0, 0);
        ticks(1);
        check_time("resume_1000", 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
